// File: rtl/perip_divider_gen_if.sv
// Slave bus bundle shared by the rv32i peripheral cores.
//   d_in  : write data from the bus master
//   cs    : chip select
//   addr  : word address (addr[4:2] of the byte address)
//   rd/wr : read / write strobes, qualified by cs
//   d_out : registered read data from the peripheral
interface perip_divider_gen_if;
    logic [31:0] d_in;
    logic        cs;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;

    modport master (output d_in, cs, addr, rd, wr, input d_out);
    modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/perip_divider_gen.sv
// Memory-mapped iterative integer divider (restoring, one quotient bit per
// clock) with signed/unsigned mode and RISC-V M-extension corner cases.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave bus (d_in, cs, addr, rd, wr, d_out)
// Register map (addr[4:2]):
//   0 DVD (W)  1 DVR (W)  2 CTRL (W: bit0 start, bit1 signed)
//   3 STATUS (R: {dbz, busy, done})  4 QUOT (R)  5 REM (R)  6,7 read 0
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero completes here in one edge
// CALC  | one restoring step per cycle, WIDTH cycles
// FIX   | apply result signs, publish QUOT/REM, raise done
module perip_divider_gen #(
    parameter int WIDTH    = 32,
    parameter int clk_freq = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    perip_divider_gen_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q, dvr_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             mode_q, done_q, busy_q, dbz_q;
    logic [CW-1:0]    cnt_q;

    // working registers of the in-flight operation
    logic [WIDTH-1:0] quo_w, rem_w, dvr_mag;
    logic             neg_q_w, neg_r_w;

    logic             wr_en, rd_en, start_ok;
    logic             load, dbz_start, step, finish;
    logic             sgn_in, dvd_neg_c, dvr_neg_c;
    logic [WIDTH-1:0] dvd_abs, dvr_abs;
    logic [WIDTH:0]   shifted, trial;
    logic             ge;
    logic [WIDTH-1:0] rem_step, quo_step, q_fix, r_fix;
    logic [31:0]      quot_ext, rem_ext, rd_data;

    logic unused_sig;
    assign unused_sig = ^{bus.d_in, (clk_freq != 0)};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        wr_en     = bus.cs & bus.wr;
        rd_en     = bus.cs & bus.rd;
        start_ok  = wr_en && (bus.addr == 3'd2) && bus.d_in[0] && (state_q == IDLE);
        state_d   = state_q;
        load      = 1'b0;
        dbz_start = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (dvr_q == '0) begin
                        dbz_start = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sgn_in    = bus.d_in[1];
        dvd_neg_c = sgn_in & dvd_q[WIDTH-1];
        dvr_neg_c = sgn_in & dvr_q[WIDTH-1];
        dvd_abs   = dvd_neg_c ? (~dvd_q + 1'b1) : dvd_q;
        dvr_abs   = dvr_neg_c ? (~dvr_q + 1'b1) : dvr_q;
        // The shifted partial remainder is below 2*divisor, so the sign bit
        // of the (WIDTH+1)-bit difference is a valid "does not fit" flag.
        shifted   = {rem_w, quo_w[WIDTH-1]};
        trial     = shifted - {1'b0, dvr_mag};
        ge        = ~trial[WIDTH];
        rem_step  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step  = {quo_w[WIDTH-2:0], ge};
        q_fix     = neg_q_w ? (~quo_w + 1'b1) : quo_w;
        r_fix     = neg_r_w ? (~rem_w + 1'b1) : rem_w;
    end

    always_comb begin
        quot_ext = mode_q ? 32'($signed(quot_q)) : 32'(quot_q);
        rem_ext  = mode_q ? 32'($signed(rem_q))  : 32'(rem_q);
        rd_data  = '0;
        case (bus.addr)
            3'd3:    rd_data = {29'b0, dbz_q, busy_q, done_q};
            3'd4:    rd_data = quot_ext;
            3'd5:    rd_data = rem_ext;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dvr_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            quo_w     <= '0;
            rem_w     <= '0;
            dvr_mag   <= '0;
            neg_q_w   <= 1'b0;
            neg_r_w   <= 1'b0;
            bus.d_out <= '0;
        end else begin
            if (wr_en && bus.addr == 3'd0) dvd_q <= bus.d_in[WIDTH-1:0];
            if (wr_en && bus.addr == 3'd1) dvr_q <= bus.d_in[WIDTH-1:0];

            if (dbz_start) begin
                mode_q <= sgn_in;
                quot_q <= '1;
                rem_q  <= dvd_q;
                dbz_q  <= 1'b1;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end

            if (load) begin
                mode_q  <= sgn_in;
                neg_q_w <= dvd_neg_c ^ dvr_neg_c;
                neg_r_w <= dvd_neg_c;
                dvr_mag <= dvr_abs;
                quo_w   <= dvd_abs;
                rem_w   <= '0;
                cnt_q   <= CW'(WIDTH);
                done_q  <= 1'b0;
                dbz_q   <= 1'b0;
                busy_q  <= 1'b1;
            end

            if (step) begin
                quo_w <= quo_step;
                rem_w <= rem_step;
                cnt_q <= cnt_q - 1'b1;
            end

            if (finish) begin
                quot_q <= q_fix;
                rem_q  <= r_fix;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end

            bus.d_out <= rd_en ? rd_data : 32'd0;
        end
    end

endmodule
